ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (for example 0xED set-LEDs or 0xF4 enable) from the FPGA to the keyboard.
- Pairs with the existing PS/2 receiver on the same open-drain ps2c/ps2d lines.
- Drives each line low only through an output-enable; the top level builds the tri-state (line = oe ? 0 : Z).
- tx_idle feeds the receiver's rx_en so the receiver ignores the host's own frame.

---
 rtl/ps2_host_tx_pkg.sv | 22 ++
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_host_tx_clk_filter.sv | 41 ++++
 rtl/ps2_host_tx.sv | 149 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing constants,
// clock-filter length shared with the receiver, and the frame parity helper.
package ps2_host_tx_pkg;

    localparam int unsigned PS2_INHIBIT_CYC = 12000;    // 120 us at 100 MHz
    localparam int unsigned PS2_TIMEOUT_CYC = 2000000;  // 20 ms at 100 MHz
    localparam int unsigned PS2_FILTER_LEN  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RTS   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // PS/2 frames carry odd parity over the eight data bits.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side bundle of the PS/2 transmitter: command request, sampled lines,
// open-drain enables and status pulses.
interface ps2_host_tx_if;

    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_err
    );

endinterface

// File: rtl/ps2_host_tx_clk_filter.sv
// Glitch filter for the PS/2 clock line: the filtered clock changes only after
// FILTER_LEN identical samples, and fall_edge_o flags its 1->0 transition.
module ps2_clk_filter
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_i,
    output logic fall_edge_o
);

    logic [FILTER_LEN-1:0] sh_q, sh_d;
    logic                  filt_q, filt_d;

    assign sh_d = {ps2c_i, sh_q[FILTER_LEN-1:1]};

    always_comb begin
        filt_d = filt_q;
        if (sh_q == {FILTER_LEN{1'b1}}) begin
            filt_d = 1'b1;
        end else if (sh_q == {FILTER_LEN{1'b0}}) begin
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q   <= '0;
            filt_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            filt_q <= filt_d;
        end
    end

    // Flag the edge one cycle early, from the value about to be registered.
    assign fall_edge_o = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: holds ps2c low for request-to-send, then
// shifts {parity, din} out on device clock falls. Define PS2_TX_TIMEOUT_EN for a watchdog abort.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = PS2_INHIBIT_CYC,
    parameter int unsigned FILTER_LEN  = PS2_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYC = PS2_TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         reset,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned C_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;

    tx_state_e      state_q, state_d;
    logic [C_W-1:0] c_q, c_d;
    logic [3:0]     n_q, n_d;
    logic [8:0]     b_q, b_d;
    logic           fall_edge;
    logic           done_tick;
    logic           err_tick;
    logic           unused_sink;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk         (clk),
        .reset       (reset),
        .ps2c_i      (bus.ps2c_in),
        .fall_edge_o (fall_edge)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYC - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            framing;

    assign framing = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
`endif

    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        n_d       = n_q;
        b_d       = b_q;
        done_tick = 1'b0;
        err_tick  = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.wr_ps2) begin
                    b_d     = {odd_parity(bus.din), bus.din};
                    c_d     = C_W'(INHIBIT_CYC - 1);
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                if (c_q == '0) begin
                    state_d = ST_START;
                end else begin
                    c_d = c_q - 1'b1;
                end
            end
            ST_START: begin
                if (fall_edge) begin
                    n_d     = 4'd8;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fall_edge) begin
                    b_d = {1'b0, b_q[8:1]};
                    if (n_q == 4'd0) begin
                        state_d = ST_STOP;
                    end else begin
                        n_d = n_q - 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (fall_edge) begin
                    done_tick = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        // A device edge counts as progress even if it lands on the expiry cycle.
        if (state_q == ST_RTS && c_q == '0) begin
            wd_d = WD_RELOAD;
        end else if (framing) begin
            if (fall_edge) begin
                wd_d = WD_RELOAD;
            end else if (wd_q == '0) begin
                err_tick = 1'b1;
                state_d  = ST_IDLE;
            end else begin
                wd_d = wd_q - 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            n_q     <= n_d;
        end
    end

    always_ff @(posedge clk) begin
        b_q <= b_d;
    end

`ifdef PS2_TX_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign bus.tx_err = err_tick;
`else
    assign bus.tx_err = 1'b0;
`endif

    // Open-drain enables decode straight from the state register, so reset releases both lines at once.
    assign bus.ps2c_oe      = (state_q == ST_RTS);
    assign bus.ps2d_oe      = (state_q == ST_START) || ((state_q == ST_DATA) && !b_q[0]);
    assign bus.tx_idle      = (state_q == ST_IDLE);
    assign bus.tx_done_tick = done_tick;

    assign unused_sink = bus.ps2d_in ^ err_tick ^ (TIMEOUT_CYC == 0);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain device model, vector table,
// random bytes against a frame model, reset, glitch, busy and watchdog corners.
module tb_ps2_host_tx;

    localparam int INH  = 1200;
    localparam int TO   = 1000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0]  din;
        logic [10:0] exp_bits;
        bit          busy;
        bit          glitch;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic dev_clk = 1'b1;

    int n_chk    = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Open-drain lines with pull-ups; the device never pulls data in this direction.
    assign bus.ps2c_in = ~bus.ps2c_oe & dev_clk;
    assign bus.ps2d_in = ~bus.ps2d_oe;

    always @(negedge clk) begin
        if (bus.tx_done_tick) done_cnt <= done_cnt + 1;
        if (bus.tx_err)       err_cnt  <= err_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame as seen by the device: start 0, d0..d7, odd parity, stop 1 (bit i = i-th sample).
    function automatic logic [10:0] frame_model(input logic [7:0] d);
        logic q[$];
        int   ones;
        logic [10:0] r;
        ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            q.push_back(d[i]);
            if (d[i]) ones++;
        end
        q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
        q.push_back(1'b1);
        for (int i = 0; i < 11; i++) r[i] = q[i];
        return r;
    endfunction

    task automatic request(input logic [7:0] d);
        @(posedge clk);
        #1 bus.wr_ps2 = 1'b1;
        bus.din = d;
        @(posedge clk);
        #1 bus.wr_ps2 = 1'b0;
    endtask

    task automatic measure_rts(output int cnt);
        cnt = 0;
        for (int k = 0; k < INH + 100; k++) begin
            @(negedge clk);
            if (bus.ps2c_oe) cnt++;
            else break;
        end
    endtask

    task automatic device_clock(input int nbits, input bit busy, input bit glitch,
                                output logic [10:0] bits, output int done_before_last);
        bits = '0;
        done_before_last = done_cnt;
        repeat (30) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (glitch && i == 5) begin
                repeat (5) @(posedge clk);
                #1 dev_clk = 1'b0;
                repeat (3) @(posedge clk);
                #1 dev_clk = 1'b1;
                repeat (HALF - 8) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 bits[i] = ~bus.ps2d_oe;
            if (i == nbits - 1) done_before_last = done_cnt;
            dev_clk = 1'b0;
            if (busy && i == 3) begin
                @(posedge clk);
                #1 bus.wr_ps2 = 1'b1;
                bus.din = 8'h55;
                @(posedge clk);
                #1 bus.wr_ps2 = 1'b0;
                repeat (HALF - 2) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1 dev_clk = 1'b1;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [10:0] exp_bits,
                             input bit busy, input bit glitch);
        int          base;
        int          cnt;
        int          db;
        logic [10:0] bits;
        base = done_cnt;
        request(d);
        measure_rts(cnt);
        check("inhibit_len", cnt, INH);
        check("start_bit_drive", bus.ps2d_oe, 1'b1);
        check("clk_released", bus.ps2c_oe, 1'b0);
        device_clock(11, busy, glitch, bits, db);
        check("no_done_before_edge11", db - base, 0);
        repeat (30) @(posedge clk);
        #1;
        check("frame_bits", bits, exp_bits);
        check("done_count", done_cnt - base, 1);
        check("idle_after", bus.tx_idle, 1'b1);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [7:0]  rd;
        int          base_d, base_e, cnt, start_cnt, err_at, db;
        logic [10:0] bits;

        tbl[0] = '{din: 8'hED, exp_bits: 11'h7DA, busy: 1'b0, glitch: 1'b0};
        tbl[1] = '{din: 8'hF4, exp_bits: 11'h5E8, busy: 1'b0, glitch: 1'b0};
        tbl[2] = '{din: 8'h00, exp_bits: 11'h600, busy: 1'b0, glitch: 1'b0};
        tbl[3] = '{din: 8'hFF, exp_bits: 11'h7FE, busy: 1'b0, glitch: 1'b0};
        tbl[4] = '{din: 8'h3C, exp_bits: 11'h678, busy: 1'b1, glitch: 1'b0};
        tbl[5] = '{din: 8'h81, exp_bits: 11'h702, busy: 1'b0, glitch: 1'b1};

        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ps2c_oe", bus.ps2c_oe, 1'b0);
        check("rst_ps2d_oe", bus.ps2d_oe, 1'b0);
        check("rst_tx_idle", bus.tx_idle, 1'b1);
        check("rst_done", bus.tx_done_tick, 1'b0);
        check("rst_err", bus.tx_err, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", bus.tx_idle, 1'b1);

        for (int v = 0; v < 6; v++) begin
            run_frame(tbl[v].din, tbl[v].exp_bits, tbl[v].busy, tbl[v].glitch);
        end

        for (int r = 0; r < 6; r++) begin
            rd = 8'($urandom_range(0, 255));
            run_frame(rd, frame_model(rd), 1'b0, 1'b0);
        end

        // Asynchronous reset while shifting data: lines release without a clock edge.
        base_d = done_cnt;
        request(8'h5A);
        measure_rts(cnt);
        device_clock(3, 1'b0, 1'b0, bits, db);
        repeat (5) @(posedge clk);
        #1;
        check("mid_frame_busy", bus.tx_idle, 1'b0);
        check("mid_frame_d2_low", bus.ps2d_oe, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ps2c_oe", bus.ps2c_oe, 1'b0);
        check("async_rst_ps2d_oe", bus.ps2d_oe, 1'b0);
        check("async_rst_idle", bus.tx_idle, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        device_clock(8, 1'b0, 1'b0, bits, db);
        repeat (30) @(posedge clk);
        #1;
        check("no_done_after_rst", done_cnt - base_d, 0);
        check("idle_after_rst", bus.tx_idle, 1'b1);
        check("ps2c_free_after_rst", bus.ps2c_oe, 1'b0);

        // Device that never clocks.
        base_d = done_cnt;
        base_e = err_cnt;
        request(8'hF4);
        measure_rts(cnt);
        check("to_inhibit_len", cnt, INH);
`ifdef PS2_TX_TIMEOUT_EN
        start_cnt = 1;
        err_at    = 0;
        for (int k = 0; k < 3 * TO; k++) begin
            @(negedge clk);
            if (bus.ps2d_oe) start_cnt++;
            if (bus.tx_err) begin
                err_at = start_cnt;
                break;
            end
        end
        check("to_err_cycle", err_at, TO);
        @(negedge clk);
        check("to_idle", bus.tx_idle, 1'b1);
        check("to_ps2c_oe", bus.ps2c_oe, 1'b0);
        check("to_ps2d_oe", bus.ps2d_oe, 1'b0);
        check("to_err_pulses", err_cnt - base_e, 1);
        check("to_no_done", done_cnt - base_d, 0);
`else
        start_cnt = 0;
        err_at    = 0;
        repeat (TO + 500) @(negedge clk);
        @(negedge clk);
        check("noto_err_zero", err_cnt - base_e, 0);
        check("noto_hung_busy", bus.tx_idle, 1'b0);
        check("noto_start_bit", bus.ps2d_oe, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("noto_recover_idle", bus.tx_idle, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
